stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-5 stream demultiplexer, the distribution counterpart of the 5:1 data mux. A single DATA_W-bit input stream with valid/ready handshake is routed by a per-beat 3-bit select to one of five output channels. Each output channel has its own one-entry holding register and valid/ready handshake. Illegal select codes are consumed, dropped and counted.

## Interface
- DATA_W, 4, width of the data path and of every output channel
- ERR_W, 8, width of the saturating illegal-select counter
- i_clk  in  1  clock; all state changes on its rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low; one clock, no other reset
- i_data  in  DATA_W  input beat payload
- i_ctrl  in  3  destination select for the current beat; 0..4 legal, 5..7 illegal
- i_valid  in  1  input beat present
- o_ready  out  1  input beat accepted this cycle when i_valid && o_ready
- o_data0 .. o_data4  out  DATA_W each  channel payloads, registered
- o_valid  out  5  bit k = channel k holds a beat
- i_ready  in  5  bit k = downstream of channel k consumes this cycle
- o_err  out  1  one-cycle pulse, registered, when an illegal-select beat is consumed
- o_err_cnt  out  ERR_W  count of consumed illegal-select beats, saturating

## Operation
- Per channel k: register data_q[k], flag o_valid[k]. o_data<k> = data_q[k].
- Input acceptance, combinational:
  - i_ctrl ≥ 5: o_ready = 1.
  - i_ctrl = k ≤ 4: o_ready = !o_valid[k] || i_ready[k].
- o_ready depends on i_ctrl and i_ready in the same cycle. This combinational path is intended.
- o_ready does not depend on i_valid.
- Channel drain: o_valid[k] && i_ready[k] retires the beat in channel k.
- Channel load: i_valid && o_ready && i_ctrl == k writes i_data into data_q[k] and sets o_valid[k].
- Drain and load of the same channel in the same cycle: the new beat is loaded and o_valid[k] stays 1. No bubble.
- Drain only: o_valid[k] clears. data_q[k] holds its old value.
- data_q[k] changes only on a load. It is stable while o_valid[k] && !i_ready[k].
- Channels are independent. Any set of channels may drain in the same cycle. At most one channel loads per cycle.
- Illegal beat (i_valid && i_ctrl ≥ 5):
  - consumed with no channel update;
  - o_err = 1 in the next cycle;
  - o_err_cnt increments and saturates at 2^ERR_W−1 (no wrap).
- o_err is 0 in any cycle that does not follow an illegal consumption.
- i_ready[k] with o_valid[k] = 0 has no effect.
- i_valid = 0: no state change apart from drains; i_data and i_ctrl are ignored.
- Reset asserted, including mid-transfer:
  - immediately, asynchronously: o_valid = 0, all o_data<k> = 0, o_err = 0, o_err_cnt = 0;
  - beats held in channels are discarded.
- First load is possible on the first rising edge after i_rst_n deasserts.

## Timing
- Latency: a beat accepted at edge N appears on o_data<k>/o_valid[k] after edge N. It can be consumed at edge N+1.
- Throughput: one beat per cycle sustained to any single channel whose i_ready is held high.
- Backpressure: a full channel k with i_ready[k] = 0 stalls only beats addressed to k. The upstream must hold i_data/i_ctrl/i_valid until accepted.
- o_err is asserted for the cycle after the illegal acceptance edge.
- o_err_cnt is updated at the same edge that o_err rises.
- Reset values: o_valid = 5'b0, o_data0..4 = 0, o_err = 0, o_err_cnt = 0, o_ready = 1 when i_ctrl is illegal or all channels are empty.

## Test plan
- Reset then routing:
  - Stimulus: i_ready = 5'b11111; send data 3,7,9,12,15 with ctrl 0..4 on consecutive cycles.
  - Required: each value appears one cycle later on o_data0..4 respectively; o_valid has exactly one bit set per cycle; o_ready stays 1.
- Backpressure on one channel:
  - Stimulus: i_ready[2] = 0; send 5 to ch2, then 6 to ch2, then 8 to ch0.
  - Required: o_data2 = 5 holds; o_ready = 0 while ctrl = 2 is presented; the ch0 beat is not accepted until upstream switches.
  - Then: raising i_ready[2] accepts 6 in the same cycle and o_valid[2] stays 1.
- Simultaneous drain/load:
  - Stimulus: ch4 full with 10, i_ready[4] = 1, input 11 to ch4.
  - Required: o_data4 = 11 next cycle with o_valid[4] continuously 1.
- Illegal select:
  - Stimulus: three beats with ctrl = 5, 6, 7.
  - Required: o_ready = 1 for each; o_valid is unchanged; o_err pulses 3 cycles; o_err_cnt = 3.
  - Also: ERR_W = 2 with 5 illegal beats gives o_err_cnt saturating at 3.
- Reset mid-operation:
  - Stimulus: fill all five channels with i_ready = 0; assert i_rst_n = 0 between edges.
  - Required: o_valid = 0, all o_data = 0 and o_err_cnt = 0 immediately, before the next edge.
- Random regression:
  - Stimulus: 256 beats with random data, ctrl = {$random} % 8, random i_ready.
  - Required: a scoreboard per channel matches order and values; no loss or duplication; the illegal count equals o_err_cnt.

Source files
------------

// File: rtl/stream_demux_if.sv
// Handshake bundle for the 1-to-5 stream demultiplexer: one upstream
// stream plus five downstream channels and the illegal-select status.
interface stream_demux_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ERR_W  = 8
);
    logic [DATA_W-1:0] i_data;
    logic [2:0]        i_ctrl;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data0;
    logic [DATA_W-1:0] o_data1;
    logic [DATA_W-1:0] o_data2;
    logic [DATA_W-1:0] o_data3;
    logic [DATA_W-1:0] o_data4;
    logic [4:0]        o_valid;
    logic [4:0]        i_ready;
    logic              o_err;
    logic [ERR_W-1:0]  o_err_cnt;

    // Upstream source and downstream sinks together
    modport master (
        output i_data, i_ctrl, i_valid, i_ready,
        input  o_ready, o_data0, o_data1, o_data2, o_data3, o_data4,
               o_valid, o_err, o_err_cnt
    );

    modport slave (
        input  i_data, i_ctrl, i_valid, i_ready,
        output o_ready, o_data0, o_data1, o_data2, o_data3, o_data4,
               o_valid, o_err, o_err_cnt
    );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-5 stream demultiplexer with one-entry holding register per
// channel; illegal select codes are consumed, flagged and counted.
module stream_demux #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ERR_W  = 8
) (
    input logic           i_clk,
    input logic           i_rst_n,
    stream_demux_if.slave bus
);
    localparam int unsigned NCH      = 5;
    localparam logic [2:0]  CTRL_MAX = 3'd4;

    logic [NCH-1:0][DATA_W-1:0] data_q, data_d;
    logic [NCH-1:0]             valid_q, valid_d;
    logic                       err_q, err_d;
    logic [ERR_W-1:0]           err_cnt_q, err_cnt_d;
    logic [7:0]                 ready_sel;
    logic                       accept;
    logic                       illegal;

    // Illegal codes 5..7 are always accepted; a legal code needs room in its channel
    assign ready_sel   = {3'b111, ~valid_q | bus.i_ready};
    assign bus.o_ready = ready_sel[bus.i_ctrl];
    assign accept      = bus.i_valid && bus.o_ready;
    assign illegal     = bus.i_valid && (bus.i_ctrl > CTRL_MAX);

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q & ~bus.i_ready;
        err_d     = illegal;
        err_cnt_d = err_cnt_q;
        // A load overrides a same-cycle drain, so the channel never bubbles
        for (int unsigned k = 0; k < NCH; k++) begin
            if (accept && (bus.i_ctrl == 3'(k))) begin
                data_d[k]  = bus.i_data;
                valid_d[k] = 1'b1;
            end
        end
        if (illegal && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q    <= '0;
            valid_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.o_data0   = data_q[0];
    assign bus.o_data1   = data_q[1];
    assign bus.o_data2   = data_q[2];
    assign bus.o_data3   = data_q[3];
    assign bus.o_data4   = data_q[4];
    assign bus.o_valid   = valid_q;
    assign bus.o_err     = err_q;
    assign bus.o_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_stream_demux.sv
// Directed and scoreboarded random bench for stream_demux; a second instance
// with a 2-bit error counter shares the stimulus to exercise saturation.
module tb_stream_demux;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    stream_demux_if #(.DATA_W(4), .ERR_W(8)) bus ();
    stream_demux_if #(.DATA_W(4), .ERR_W(2)) bus2 ();

    stream_demux #(.DATA_W(4), .ERR_W(8)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    stream_demux #(.DATA_W(4), .ERR_W(2)) u_dut_sat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus2)
    );

    assign bus2.i_data  = bus.i_data;
    assign bus2.i_ctrl  = bus.i_ctrl;
    assign bus2.i_valid = bus.i_valid;
    assign bus2.i_ready = bus.i_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [3:0] d, input logic v);
        bus.i_ctrl  = c;
        bus.i_data  = d;
        bus.i_valid = v;
        #1;
    endtask

    function automatic logic [3:0] get_data(input int k);
        case (k)
            0:       return bus.o_data0;
            1:       return bus.o_data1;
            2:       return bus.o_data2;
            3:       return bus.o_data3;
            default: return bus.o_data4;
        endcase
    endfunction

    initial begin
        logic [3:0] route_vals [5];
        logic [4:0] mv;
        logic [3:0] exp_data [5];
        logic       exp_rdy;
        bit         pend;
        int         acc;
        int         cyc;
        int         tail;
        int         illegal_n;

        n_checks = 0;
        n_pass   = 0;
        route_vals[0] = 4'd3;  route_vals[1] = 4'd7;  route_vals[2] = 4'd9;
        route_vals[3] = 4'd12; route_vals[4] = 4'd15;

        // Reset state
        rst_n       = 1'b1;
        bus.i_ready = 5'b11111;
        drive(3'd0, 4'd0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        check("rst_data0", 32'(bus.o_data0), 32'h0);
        check("rst_err", 32'(bus.o_err), 32'h0);
        check("rst_err_cnt", 32'(bus.o_err_cnt), 32'h0);
        check("rst_ready", 32'(bus.o_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Routing to each channel on consecutive cycles
        for (int i = 0; i < 5; i++) begin
            drive(3'(i), route_vals[i], 1'b1);
            check("route_ready", 32'(bus.o_ready), 32'h1);
            tick();
            check("route_data", 32'(get_data(i)), 32'(route_vals[i]));
            check("route_valid", 32'(bus.o_valid), 32'(5'b00001 << i));
        end
        drive(3'd0, 4'd0, 1'b0);
        tick();
        check("route_drained", 32'(bus.o_valid), 32'h0);

        // Backpressure on channel 2
        bus.i_ready = 5'b11011;
        drive(3'd2, 4'd5, 1'b1);
        tick();
        check("bp_data2", 32'(bus.o_data2), 32'd5);
        drive(3'd2, 4'd6, 1'b1);
        check("bp_ready_stall", 32'(bus.o_ready), 32'h0);
        tick();
        check("bp_data2_hold", 32'(bus.o_data2), 32'd5);
        check("bp_valid_hold", 32'(bus.o_valid), 32'b00100);
        drive(3'd0, 4'd8, 1'b1);
        check("bp_ready_ch0", 32'(bus.o_ready), 32'h1);
        tick();
        check("bp_data0", 32'(bus.o_data0), 32'd8);
        check("bp_valid_both", 32'(bus.o_valid), 32'b00101);
        bus.i_ready = 5'b11111;
        drive(3'd2, 4'd6, 1'b1);
        check("bp_ready_release", 32'(bus.o_ready), 32'h1);
        tick();
        check("bp_data2_new", 32'(bus.o_data2), 32'd6);
        check("bp_valid_new", 32'(bus.o_valid), 32'b00100);
        drive(3'd0, 4'd0, 1'b0);
        tick();
        check("bp_drain_valid", 32'(bus.o_valid), 32'h0);
        check("bp_drain_data_kept", 32'(bus.o_data2), 32'd6);

        // Simultaneous drain and load on channel 4
        bus.i_ready = 5'b01111;
        drive(3'd4, 4'd10, 1'b1);
        tick();
        check("dl_data4_first", 32'(bus.o_data4), 32'd10);
        bus.i_ready = 5'b11111;
        drive(3'd4, 4'd11, 1'b1);
        check("dl_ready", 32'(bus.o_ready), 32'h1);
        tick();
        check("dl_data4_second", 32'(bus.o_data4), 32'd11);
        check("dl_valid4", 32'(bus.o_valid), 32'b10000);
        drive(3'd0, 4'd0, 1'b0);
        tick();

        // Illegal selects, with channel 1 held full
        bus.i_ready = 5'b00000;
        drive(3'd1, 4'd3, 1'b1);
        tick();
        for (int c = 5; c < 8; c++) begin
            drive(3'(c), 4'(c), 1'b1);
            check("ill_ready", 32'(bus.o_ready), 32'h1);
            tick();
            check("ill_err", 32'(bus.o_err), 32'h1);
            check("ill_valid", 32'(bus.o_valid), 32'b00010);
            check("ill_cnt", 32'(bus.o_err_cnt), 32'(c - 4));
        end
        drive(3'd0, 4'd0, 1'b0);
        tick();
        check("ill_err_clear", 32'(bus.o_err), 32'h0);
        check("ill_cnt3", 32'(bus.o_err_cnt), 32'd3);
        check("ill_data1", 32'(bus.o_data1), 32'd3);
        drive(3'd6, 4'd1, 1'b1);
        tick();
        tick();
        drive(3'd0, 4'd0, 1'b0);
        tick();
        check("ill_cnt5", 32'(bus.o_err_cnt), 32'd5);
        check("ill_sat_cnt", 32'(bus2.o_err_cnt), 32'd3);

        // Reset mid-operation with all channels full
        bus.i_ready = 5'b11111;
        tick();
        bus.i_ready = 5'b00000;
        for (int k = 0; k < 5; k++) begin
            drive(3'(k), 4'(k + 1), 1'b1);
            tick();
        end
        check("fill_valid", 32'(bus.o_valid), 32'b11111);
        check("fill_data4", 32'(bus.o_data4), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(bus.o_valid), 32'h0);
        check("mrst_data",
              32'({bus.o_data0, bus.o_data1, bus.o_data2, bus.o_data3, bus.o_data4}), 32'h0);
        check("mrst_cnt", 32'(bus.o_err_cnt), 32'h0);
        drive(3'd3, 4'd9, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("first_load", 32'(bus.o_data3), 32'd9);
        check("first_valid", 32'(bus.o_valid), 32'b01000);
        bus.i_ready = 5'b11111;
        drive(3'd0, 4'd0, 1'b0);
        tick();

        // Random regression with a one-deep scoreboard per channel
        mv        = 5'b0;
        pend      = 1'b0;
        acc       = 0;
        cyc       = 0;
        tail      = 0;
        illegal_n = 0;
        for (int k = 0; k < 5; k++) exp_data[k] = 4'd0;
        while ((acc < 256 || tail < 2) && cyc < 4000) begin
            cyc++;
            if (acc >= 256) begin
                tail++;
                bus.i_ready = 5'b11111;
                drive(3'd0, 4'd0, 1'b0);
            end else begin
                bus.i_ready = 5'($urandom);
                if (!pend) begin
                    drive(3'($urandom_range(0, 7)), 4'($urandom), ($urandom_range(0, 3) != 0));
                    pend = bus.i_valid;
                end else begin
                    #1;
                end
            end
            exp_rdy = (bus.i_ctrl > 3'd4) ? 1'b1
                    : (!mv[bus.i_ctrl] || bus.i_ready[bus.i_ctrl]);
            check("rnd_valid", 32'(bus.o_valid), 32'(mv));
            if (bus.i_valid) check("rnd_ready", 32'(bus.o_ready), 32'(exp_rdy));
            for (int k = 0; k < 5; k++) begin
                if (mv[k] && bus.i_ready[k]) begin
                    check("rnd_data", 32'(get_data(k)), 32'(exp_data[k]));
                    mv[k] = 1'b0;
                end
            end
            if (bus.i_valid && exp_rdy) begin
                acc++;
                pend = 1'b0;
                if (bus.i_ctrl <= 3'd4) begin
                    exp_data[bus.i_ctrl] = bus.i_data;
                    mv[bus.i_ctrl]       = 1'b1;
                end else begin
                    illegal_n++;
                end
            end
            tick();
        end
        check("rnd_budget", 32'(cyc < 4000), 32'h1);
        check("rnd_err_cnt", 32'(bus.o_err_cnt), 32'(illegal_n));
        check("rnd_empty", 32'(bus.o_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
